// File: rtl/block_interleaver_pkg.sv
// Shared types and helpers for the block interleaver.
//   stage_t     : valid/last tag carried alongside each read-pipeline stage
//   clog2_min1  : ceil(log2(v)) clamped to at least 1, for counter/pointer widths
package block_interleaver_pkg;

    typedef struct packed {
        logic valid;
        logic last;
    } stage_t;

    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/block_interleaver_sdp_ram.sv
// Simple dual-port RAM for the interleaver banks: one write port and one
// registered read port. An optional second data register provides the
// output stage when the top runs in the speed-optimized mode.
// Ports:
//   clk        : clock
//   wr_en_i    : write enable
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_en_i    : read enable (first read register advances)
//   rd_addr_i  : read address
//   out_en_i   : output register enable (only used when OUT_REG=1)
//   rd_data_o  : read data
module interleaver_sdp_ram
    import block_interleaver_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int DEPTH   = 2,
    parameter bit OUT_REG = 1'b1,
    parameter int AW      = clog2_min1(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    input  logic             out_en_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        // Read register only advances with the pipeline so stalled data holds.
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic [WIDTH-1:0] out_q;
            always_ff @(posedge clk) begin
                if (out_en_i) begin
                    out_q <= rd_data_q;
                end
            end
            assign rd_data_o = out_q;
        end else begin : g_no_out_reg
            logic unused_out_en;
            assign unused_out_en = out_en_i;
            assign rd_data_o     = rd_data_q;
        end
    endgenerate

endmodule

// File: rtl/block_interleaver.sv
// Row/column block interleaver. Symbols arrive on an AXI4-Stream slave and
// are written row-major into a row x col matrix; full matrices are read out
// column-major on an AXI4-Stream master with tlast on the final symbol.
// deepth banks are buffered so input and output run concurrently.
// Ports:
//   clk            : clock, rising edge
//   rst_n          : asynchronous reset, active-high
//   s_axis_tdata   : input symbol
//   s_axis_tvalid  : input valid
//   s_axis_tready  : input ready (current write bank not full)
//   m_axis_tdata   : interleaved output symbol (0 while tvalid is low)
//   m_axis_tvalid  : output valid
//   m_axis_tlast   : last symbol of a block
//   m_axis_tready  : output ready
module block_interleaver
    import block_interleaver_pkg::*;
#(
    parameter int    deepth = 4,
    parameter string mode   = "Speed_optimized",
    parameter int    width  = 1,
    parameter int    row    = 512,
    parameter int    col    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [width-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready
);

    localparam int N     = row * col;
    localparam int AW    = clog2_min1(N);
    localparam int BW    = clog2_min1(deepth);
    localparam int RW    = clog2_min1(row);
    localparam int CW    = clog2_min1(col);
    localparam int RAW   = clog2_min1(deepth * N);
    localparam bit SPEED = (mode == "Speed_optimized");
    localparam bit AREA  = (mode == "Area_optimized");

    // Write side
    logic [BW-1:0]     wr_bank_q, wr_bank_d;
    logic [AW-1:0]     wr_cnt_q, wr_cnt_d;
    logic [deepth-1:0] full_q, full_d;
    logic              wr_fire, wr_last;

    // Read issue side: r runs fast, c slow; rd_off tracks r*col+c directly
    logic [BW-1:0]     rd_bank_q, rd_bank_d;
    logic [RW-1:0]     rd_r_q, rd_r_d;
    logic [CW-1:0]     rd_c_q, rd_c_d;
    logic [AW-1:0]     rd_off_q, rd_off_d;
    logic [BW-1:0]     free_bank_q, free_bank_d;
    logic              rd_avail, rd_is_last, issue;

    // Read pipeline
    stage_t            s1_q, s1_d;
    logic              en1, en2;
    logic              out_valid, out_last, out_fire;
    logic [width-1:0]  ram_rdata;
    logic [RAW-1:0]    ram_waddr, ram_raddr;

    assign s_axis_tready = !rst_n && !full_q[wr_bank_q];
    assign wr_fire       = s_axis_tvalid && s_axis_tready;
    assign wr_last       = (wr_cnt_q == AW'(N - 1));

    // A bank that completes this cycle can already be read from: its first
    // read address (offset 0) never collides with the final write (N-1).
    assign rd_avail   = full_q[rd_bank_q] ||
                        (wr_fire && wr_last && (wr_bank_q == rd_bank_q));
    assign rd_is_last = (rd_r_q == RW'(row - 1)) && (rd_c_q == CW'(col - 1));
    assign issue      = rd_avail && en1;
    assign out_fire   = out_valid && m_axis_tready;

    assign ram_waddr = RAW'(wr_bank_q) * RAW'(N) + RAW'(wr_cnt_q);
    assign ram_raddr = RAW'(rd_bank_q) * RAW'(N) + RAW'(rd_off_q);

    always_comb begin
        wr_bank_d   = wr_bank_q;
        wr_cnt_d    = wr_cnt_q;
        full_d      = full_q;
        rd_bank_d   = rd_bank_q;
        rd_r_d      = rd_r_q;
        rd_c_d      = rd_c_q;
        rd_off_d    = rd_off_q;
        free_bank_d = free_bank_q;
        s1_d.valid  = issue;
        s1_d.last   = issue && rd_is_last;

        if (wr_fire) begin
            if (wr_last) begin
                wr_cnt_d          = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = (wr_bank_q == BW'(deepth - 1)) ? '0 : wr_bank_q + 1'b1;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end

        if (issue) begin
            if (rd_r_q == RW'(row - 1)) begin
                rd_r_d = '0;
                if (rd_c_q == CW'(col - 1)) begin
                    rd_c_d    = '0;
                    rd_off_d  = '0;
                    rd_bank_d = (rd_bank_q == BW'(deepth - 1)) ? '0 : rd_bank_q + 1'b1;
                end else begin
                    rd_c_d   = rd_c_q + 1'b1;
                    rd_off_d = AW'(rd_c_q) + 1'b1;
                end
            end else begin
                rd_r_d   = rd_r_q + 1'b1;
                rd_off_d = rd_off_q + AW'(col);
            end
        end

        // Bank is released only once the sink has taken the block's last symbol.
        // The writer never targets a full bank, so this never races the set above.
        if (out_fire && out_last) begin
            full_d[free_bank_q] = 1'b0;
            free_bank_d = (free_bank_q == BW'(deepth - 1)) ? '0 : free_bank_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_bank_q   <= '0;
            wr_cnt_q    <= '0;
            full_q      <= '0;
            rd_bank_q   <= '0;
            rd_r_q      <= '0;
            rd_c_q      <= '0;
            rd_off_q    <= '0;
            free_bank_q <= '0;
            s1_q        <= '0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            full_q      <= full_d;
            rd_bank_q   <= rd_bank_d;
            rd_r_q      <= rd_r_d;
            rd_c_q      <= rd_c_d;
            rd_off_q    <= rd_off_d;
            free_bank_q <= free_bank_d;
            if (en1) begin
                s1_q <= s1_d;
            end
        end
    end

    // Stage tags move in lockstep with the RAM data registers; each stage
    // loads whenever it is empty or its downstream is taking its contents,
    // which gives one symbol per clock with no bubbles under tready=1.
    generate
        if (SPEED) begin : g_speed
            stage_t s2_q;
            assign en2 = !s2_q.valid || m_axis_tready;
            assign en1 = !s1_q.valid || en2;
            always_ff @(posedge clk or posedge rst_n) begin
                if (rst_n) begin
                    s2_q <= '0;
                end else if (en2) begin
                    s2_q <= s1_q;
                end
            end
            assign out_valid = s2_q.valid;
            assign out_last  = s2_q.last;
        end else if (AREA) begin : g_area
            assign en2       = 1'b0;
            assign en1       = !s1_q.valid || m_axis_tready;
            assign out_valid = s1_q.valid;
            assign out_last  = s1_q.last;
        end else begin : g_bad_mode
            $error("block_interleaver: unsupported mode '%s'", mode);
        end
    endgenerate

    interleaver_sdp_ram #(
        .WIDTH   (width),
        .DEPTH   (deepth * N),
        .OUT_REG (SPEED),
        .AW      (RAW)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_fire),
        .wr_addr_i (ram_waddr),
        .wr_data_i (s_axis_tdata),
        .rd_en_i   (en1),
        .rd_addr_i (ram_raddr),
        .out_en_i  (en2),
        .rd_data_o (ram_rdata)
    );

    assign m_axis_tvalid = out_valid;
    assign m_axis_tlast  = out_last;
    // RAM registers carry no reset; gating keeps tdata at 0 whenever idle.
    assign m_axis_tdata  = out_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_block_interleaver.sv
module tb_block_interleaver;

    localparam int ROW = 2;
    localparam int COL = 3;
    localparam int N   = ROW * COL;
    localparam int W   = 8;
    localparam int LAT = 2;

    logic         clk           = 1'b0;
    logic         rst_n         = 1'b1;
    logic [W-1:0] s_axis_tdata  = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic [W-1:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready = 1'b0;

    always #5 clk = ~clk;

    block_interleaver #(
        .deepth (2),
        .mode   ("Speed_optimized"),
        .width  (W),
        .row    (ROW),
        .col    (COL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] blk_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           lat_cyc = 0;
    int           n_out = 0;
    bit           lat_armed = 1'b0;
    bit           prev_stall = 1'b0;
    logic         obs_mvalid, obs_mlast, obs_stready, obs_acc;
    logic [W-1:0] obs_mdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: sample at the falling edge, update the reference model with
    // the handshakes that the next rising edge will complete, then return
    // just after that edge so callers can drive new inputs.
    task automatic step();
        @(negedge clk);
        obs_mvalid  = m_axis_tvalid;
        obs_mlast   = m_axis_tlast;
        obs_mdata   = m_axis_tdata;
        obs_stready = s_axis_tready;
        obs_acc     = s_axis_tvalid && s_axis_tready;

        if (prev_stall) check_eq("hold_valid", m_axis_tvalid, 1);
        prev_stall = m_axis_tvalid && !m_axis_tready;

        if (m_axis_tvalid) begin
            if (lat_armed) begin
                check_eq("latency", cyc - lat_cyc, LAT);
                lat_armed = 1'b0;
            end
            if (exp_q.size() == 0) begin
                check_eq("spurious_valid", m_axis_tvalid, 0);
            end else begin
                check_eq("tdata", m_axis_tdata, exp_q[0].data);
                check_eq("tlast", m_axis_tlast, exp_q[0].last);
                if (m_axis_tready) begin
                    $display("out %0d: data=0x%02h last=%0b", n_out, m_axis_tdata, m_axis_tlast);
                    n_out++;
                    void'(exp_q.pop_front());
                end
            end
        end

        if (obs_acc) begin
            blk_q.push_back(s_axis_tdata);
            if (blk_q.size() == N) begin
                if (exp_q.size() == 0) begin
                    lat_armed = 1'b1;
                    lat_cyc   = cyc;
                end
                for (int c = 0; c < COL; c++)
                    for (int r = 0; r < ROW; r++)
                        exp_q.push_back('{data: blk_q[r*COL + c],
                                          last: (c == COL-1) && (r == ROW-1)});
                blk_q.delete();
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d);
        int guard = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        do begin
            step();
            guard++;
        end while (!obs_acc && guard < 200);
        check_eq("send_accept", obs_acc, 1);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b0;
        while (exp_q.size() != 0 && guard < 500) begin
            step();
            guard++;
        end
        check_eq("drain_empty", exp_q.size(), 0);
        repeat (3) step();
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        exp_q.delete();
        blk_q.delete();
        lat_armed  = 1'b0;
        prev_stall = 1'b0;
        #1;
        check_eq("rst_s_tready", s_axis_tready, 0);
        check_eq("rst_m_tvalid", m_axis_tvalid, 0);
        check_eq("rst_m_tlast", m_axis_tlast, 0);
        check_eq("rst_m_tdata", m_axis_tdata, 0);
        repeat (2) step();
        rst_n = 1'b0;
        step();
        check_eq("exit_s_tready", obs_stready, 1);
        check_eq("exit_m_tvalid", obs_mvalid, 0);
        check_eq("exit_m_tdata", obs_mdata, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        apply_reset();

        // Directed block 0..5 -> 0,3,1,4,2,5, with latency check
        m_axis_tready = 1'b1;
        for (int i = 0; i < N; i++) send(W'(i));
        drain();
        check_eq("lat_seen", lat_armed, 0);

        // Full buffering with sink stalled, then gapless drain
        begin
            int  acc = 0;
            bit  need_new = 1'b1;
            m_axis_tready = 1'b0;
            for (int i = 0; i < 20; i++) begin
                s_axis_tvalid = 1'b1;
                if (need_new) s_axis_tdata = W'($urandom);
                step();
                need_new = obs_acc;
                if (obs_acc) acc++;
            end
            check_eq("stall_accepted", acc, 2 * N);
            check_eq("stall_s_tready", obs_stready, 0);
            s_axis_tvalid = 1'b0;
            m_axis_tready = 1'b1;
            for (int i = 0; i < 2 * N; i++) begin
                step();
                check_eq("drain_no_gap", obs_mvalid, 1);
                if (i <= N - 1) check_eq("s_tready_before_free", obs_stready, 0);
                if (i == N)     check_eq("s_tready_after_free", obs_stready, 1);
            end
            drain();
        end

        // Random data, random source valid and random sink ready, 4 blocks
        begin
            int sent = 0;
            int guard = 0;
            bit need_new = 1'b1;
            while (sent < 4 * N && guard < 2000) begin
                if (need_new || !s_axis_tvalid) begin
                    s_axis_tvalid = ($urandom_range(0, 3) != 0);
                    s_axis_tdata  = W'($urandom);
                end
                m_axis_tready = $urandom_range(0, 1) == 1;
                step();
                need_new = obs_acc;
                if (obs_acc) sent++;
                guard++;
            end
            check_eq("random_sent", sent, 4 * N);
            drain();
        end

        // Reset in the middle of a block; next block starts fresh
        m_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) send(W'($urandom));
        apply_reset();
        m_axis_tready = 1'b1;
        for (int i = 0; i < N; i++) send(W'(i + 8'h40));
        drain();

        // Partial block stays put until completed
        for (int i = 0; i < N - 1; i++) send(W'($urandom));
        for (int i = 0; i < 100; i++) begin
            step();
            if (i % 25 == 0) check_eq("partial_idle", obs_mvalid, 0);
        end
        send(W'($urandom));
        drain();
        check_eq("partial_lat_seen", lat_armed, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
